spike_event_fifo: RTL and testbench



---
 rtl/spike_event_fifo.sv | 121 ++++++++++++
 tb/tb_spike_event_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_fifo.sv
// spike_event_fifo
//   Buffers {spike value, neuron id} events from the network selector stage
//   and presents them in order to the neuron-update engine over valid/ready.
//   Zero-valued spikes can be filtered. Accepted/dropped events are counted
//   with saturating counters, and a sticky flag records lost events.
//
// Ports
//   clk, reset      : single clock, synchronous active-high reset
//   top_en_network  : global step enable, gates the input side only
//   network_done    : one-cycle pulse qualifying spike_event
//   spike_event     : {spike value, neuron id}
//   drop_zero       : discard events whose spike value is 0
//   clear_stats     : synchronous clear of counters and overflow
//   out_valid/ready : head-of-queue handshake
//   out_spike/id    : head event fields (forced to 0 while empty)
//   fifo_count      : occupancy, 0..DEPTH
//   overflow        : sticky, set when an event is lost to a full FIFO
//   event_cnt       : accepted events, saturating
//   drop_cnt        : filtered events, saturating
module spike_event_fifo #(
  parameter int TEN_DATA_WIDTH  = 2,
  parameter int NEURON_ID_WIDTH = 8,
  parameter int DEPTH           = 16,
  parameter int PTR_WIDTH       = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      top_en_network,
  input  logic                                      network_done,
  input  logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] spike_event,
  input  logic                                      drop_zero,
  input  logic                                      clear_stats,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [TEN_DATA_WIDTH-1:0]                 out_spike,
  output logic [NEURON_ID_WIDTH-1:0]                out_id,
  output logic [PTR_WIDTH:0]                        fifo_count,
  output logic                                      overflow,
  output logic [CNT_WIDTH-1:0]                      event_cnt,
  output logic [CNT_WIDTH-1:0]                      drop_cnt
);

  localparam int EW = TEN_DATA_WIDTH + NEURON_ID_WIDTH;
  localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);

  logic [EW-1:0]        mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [EW-1:0]        head;

  logic in_fire;
  logic is_zero;
  logic filtered;
  logic push_req;
  logic full;
  logic pop;
  logic push;
  logic lost;

  always_comb begin
    in_fire   = network_done & top_en_network;
    is_zero   = (spike_event[EW-1:NEURON_ID_WIDTH] == '0);
    filtered  = in_fire & drop_zero & is_zero;
    push_req  = in_fire & ~filtered;
    full      = (fifo_count == FULL_COUNT);
    out_valid = (fifo_count != '0);
    pop       = out_valid & out_ready;
    // A pop in the same cycle frees the slot the push lands in.
    push      = push_req & (~full | pop);
    lost      = push_req & full & ~pop;
  end

  always_comb begin
    head      = mem[rd_ptr];
    out_spike = '0;
    out_id    = '0;
    if (out_valid) begin
      out_spike = head[EW-1:NEURON_ID_WIDTH];
      out_id    = head[NEURON_ID_WIDTH-1:0];
    end
  end

  // Storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= spike_event;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // clear_stats wins over a same-cycle counting event.
  always_ff @(posedge clk) begin
    if (reset || clear_stats) begin
      event_cnt <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push && (event_cnt != '1))    event_cnt <= event_cnt + 1'b1;
      if (filtered && (drop_cnt != '1)) drop_cnt  <= drop_cnt + 1'b1;
      if (lost)                         overflow  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spike_event_fifo.sv
module tb_spike_event_fifo;

  logic       clk;
  logic       reset;
  logic       top_en_network;
  logic       network_done;
  logic [9:0] spike_event;
  logic       drop_zero;
  logic       clear_stats;
  logic       out_ready;

  logic        a_out_valid;
  logic [1:0]  a_out_spike;
  logic [7:0]  a_out_id;
  logic [4:0]  a_fifo_count;
  logic        a_overflow;
  logic [15:0] a_event_cnt;
  logic [15:0] a_drop_cnt;

  logic        b_out_valid;
  logic [1:0]  b_out_spike;
  logic [7:0]  b_out_id;
  logic [4:0]  b_fifo_count;
  logic        b_overflow;
  logic [3:0]  b_event_cnt;
  logic [3:0]  b_drop_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: a queue of events plus plain integer statistics.
  logic [9:0]  mq[$];
  int unsigned m_acc;
  int unsigned m_drp;
  bit          m_ovf;

  spike_event_fifo #(.CNT_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .top_en_network(top_en_network),
    .network_done(network_done), .spike_event(spike_event),
    .drop_zero(drop_zero), .clear_stats(clear_stats),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_spike(a_out_spike), .out_id(a_out_id),
    .fifo_count(a_fifo_count), .overflow(a_overflow),
    .event_cnt(a_event_cnt), .drop_cnt(a_drop_cnt)
  );

  spike_event_fifo #(.CNT_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset), .top_en_network(top_en_network),
    .network_done(network_done), .spike_event(spike_event),
    .drop_zero(drop_zero), .clear_stats(clear_stats),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_spike(b_out_spike), .out_id(b_out_id),
    .fifo_count(b_fifo_count), .overflow(b_overflow),
    .event_cnt(b_event_cnt), .drop_cnt(b_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_step();
    bit fire, filt, req, pop, accept;
    if (reset) begin
      mq.delete();
      m_acc = 0;
      m_drp = 0;
      m_ovf = 0;
      return;
    end
    fire   = top_en_network && network_done;
    filt   = fire && drop_zero && (spike_event[9:8] == 2'b00);
    req    = fire && !filt;
    pop    = (mq.size() > 0) && out_ready;
    accept = req && ((mq.size() < 16) || pop);
    if (pop)    void'(mq.pop_front());
    if (accept) mq.push_back(spike_event);
    if (clear_stats) begin
      m_acc = 0;
      m_drp = 0;
      m_ovf = 0;
    end else begin
      if (accept)       m_acc++;
      if (filt)         m_drp++;
      if (req && !accept) m_ovf = 1;
    end
  endtask

  task automatic compare_all();
    logic [9:0] h;
    h = (mq.size() > 0) ? mq[0] : 10'h000;
    check("out_valid",  32'(a_out_valid),  32'(mq.size() > 0));
    check("out_spike",  32'(a_out_spike),  32'(h[9:8]));
    check("out_id",     32'(a_out_id),     32'(h[7:0]));
    check("fifo_count", 32'(a_fifo_count), mq.size());
    check("overflow",   32'(a_overflow),   32'(m_ovf));
    check("event_cnt",  32'(a_event_cnt),  sat(m_acc, 65535));
    check("drop_cnt",   32'(a_drop_cnt),   sat(m_drp, 65535));
    check("event_cnt4", 32'(b_event_cnt),  sat(m_acc, 15));
    check("drop_cnt4",  32'(b_drop_cnt),   sat(m_drp, 15));
    check("fifo_count4", 32'(b_fifo_count), mq.size());
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle();
    reset        = 1'b0;
    network_done = 1'b0;
    clear_stats  = 1'b0;
    out_ready    = 1'b0;
    spike_event  = '0;
  endtask

  task automatic push(input logic [9:0] ev, input logic rdy);
    idle();
    network_done = 1'b1;
    spike_event  = ev;
    out_ready    = rdy;
    tick();
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    idle();
    top_en_network = 1'b1;
    drop_zero      = 1'b0;
    do_reset();
    do_reset();
    check("rst_count", 32'(a_fifo_count), 0);
    check("rst_valid", 32'(a_out_valid), 0);

    // Single event, one-cycle latency, then pop.
    push({2'b01, 8'h2A}, 1'b0);
    check("first_valid", 32'(a_out_valid), 1);
    check("first_id", 32'(a_out_id), 32'h2A);
    idle(); out_ready = 1'b1; tick();
    check("first_drained", 32'(a_fifo_count), 0);

    // Fill, full push with pop, overflow, drain.
    idle(); clear_stats = 1'b1; tick();
    for (int i = 0; i < 16; i++) push({2'b10, 8'(i)}, 1'b0);
    check("full_count", 32'(a_fifo_count), 16);
    push({2'b01, 8'h77}, 1'b1);
    check("full_pp_count", 32'(a_fifo_count), 16);
    check("full_pp_ovf", 32'(a_overflow), 0);
    push({2'b01, 8'h99}, 1'b0);
    check("lost_ovf", 32'(a_overflow), 1);
    check("lost_evcnt", 32'(a_event_cnt), 17);
    for (int i = 0; i < 16; i++) begin
      idle(); out_ready = 1'b1;
      if (i == 15) check("last_id", 32'(a_out_id), 32'h77);
      tick();
    end

    // Zero filter.
    do_reset();
    drop_zero = 1'b1;
    push({2'b00, 8'h05}, 1'b0);
    push({2'b11, 8'h06}, 1'b0);
    check("dz_drop", 32'(a_drop_cnt), 1);
    check("dz_ev", 32'(a_event_cnt), 1);
    check("dz_head", 32'(a_out_id), 32'h06);
    drop_zero = 1'b0;
    push({2'b00, 8'h08}, 1'b0);
    check("dz_off_count", 32'(a_fifo_count), 2);

    // Input gating, then reset with entries queued.
    top_en_network = 1'b0;
    push({2'b01, 8'h11}, 1'b0);
    check("gated_count", 32'(a_fifo_count), 2);
    top_en_network = 1'b1;
    for (int i = 0; i < 3; i++) push({2'b01, 8'(i + 8'h40)}, 1'b0);
    check("pre_rst_count", 32'(a_fifo_count), 5);
    do_reset();
    check("mid_rst_count", 32'(a_fifo_count), 0);

    // Saturation on the narrow counter, then clear against a push.
    for (int i = 0; i < 20; i++) push({2'b01, 8'(i)}, 1'b1);
    check("sat_ev4", 32'(b_event_cnt), 15);
    idle(); network_done = 1'b1; spike_event = {2'b11, 8'hC3}; clear_stats = 1'b1;
    tick();
    check("clr_ev", 32'(a_event_cnt), 0);
    check("clr_stored", 32'(a_fifo_count), 2);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      idle();
      reset          = ($urandom_range(0, 199) == 0);
      clear_stats    = ($urandom_range(0, 49) == 0);
      top_en_network = ($urandom_range(0, 7) != 0);
      network_done   = $urandom_range(0, 1);
      spike_event    = 10'($urandom);
      out_ready      = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) drop_zero = $urandom_range(0, 1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
